// File: rtl/regfile_mp_pkg.sv
// Shared core types and defaults for the multi-ported register file.
package regfile_mp_pkg;

    localparam int DEF_NREGS = 32;
    localparam int DEF_XLEN  = 32;

    typedef logic [DEF_XLEN-1:0]          word_t;
    typedef logic [$clog2(DEF_NREGS)-1:0] regnum_t;

endpackage

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register busy scoreboard and a
// sequential zeroing pass (CLEAR) after reset or on request.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int NREGS   = DEF_NREGS,
    parameter int XLEN    = DEF_XLEN,
    parameter int NRPORTS = 2,
    parameter int BYPASS  = 1,
    localparam int IW     = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_req,
    output logic                           ready,
    input  logic [NRPORTS-1:0][IW-1:0]     rd_idx,
    output logic [NRPORTS-1:0][XLEN-1:0]   rd_data,
    output logic [NRPORTS-1:0]             rd_busy,
    input  logic                           wr_en,
    input  logic [IW-1:0]                  wr_idx,
    input  logic [XLEN-1:0]                wr_data,
    input  logic                           rsv_en,
    input  logic [IW-1:0]                  rsv_idx
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              mem_we;
    logic [IW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem [NREGS];

    // Write/reserve only take effect when operating and not being cleared;
    // index 0 is hardwired to zero and never tracked.
    logic wr_ok, rsv_ok;
    assign wr_ok  = (state_q == S_READY) && !clr_req && wr_en  && (wr_idx  != '0);
    assign rsv_ok = (state_q == S_READY) && !clr_req && rsv_en && (rsv_idx != '0);

    // State, clear counter, scoreboard and ready flag; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= IW'(1);
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next-state: walk the clear counter, or update the scoreboard in READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_CLEAR: begin
                busy_d = '0;
                if (cnt_q == IW'(NREGS - 1)) state_d = S_READY;
                else                         cnt_d   = cnt_q + IW'(1);
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = IW'(1);
                    busy_d  = '0;
                end else begin
                    // Reserve is applied after the write so it wins on a tie.
                    if (wr_ok)  busy_d[wr_idx]  = 1'b0;
                    if (rsv_ok) busy_d[rsv_idx] = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = IW'(1);
                busy_d  = '0;
            end
        endcase
    end

    // Outputs: registered ready and the single array write port (clear or user).
    always_comb begin
        ready_d   = (state_d == S_READY);
        mem_we    = 1'b0;
        mem_waddr = wr_idx;
        mem_wdata = wr_data;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    assign ready = ready_q;

    // Storage array; deliberately not reset, the CLEAR pass zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Combinational read ports; all zero while clearing since the array
    // may still hold stale data there.
    for (genvar p = 0; p < NRPORTS; p++) begin : g_rd
        logic rd_ok, rd_byp;
        assign rd_ok      = (state_q == S_READY) && (rd_idx[p] != '0);
        assign rd_byp     = (BYPASS != 0) && wr_en && (wr_idx == rd_idx[p]);
        assign rd_data[p] = !rd_ok ? '0 : (rd_byp ? wr_data : mem[rd_idx[p]]);
        assign rd_busy[p] = rd_ok && busy_q[rd_idx[p]];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: three instances (32 regs bypass on/off, 16 regs 3 ports).
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst, clr_req, wr_en, rsv_en;
    logic [4:0]  wr_idx, rsv_idx;
    logic [31:0] wr_data;

    logic [1:0][4:0]  rd_idx;
    logic [1:0][31:0] rd_data_a, rd_data_b;
    logic [1:0]       rd_busy_a, rd_busy_b;
    logic             ready_a, ready_b;

    logic [2:0][3:0]  rd_idx_c;
    logic [2:0][31:0] rd_data_c;
    logic [2:0]       rd_busy_c;
    logic             ready_c;
    logic [3:0]       wr_idx_c, rsv_idx_c;

    int n_cmp = 0;
    int n_err = 0;

    assign wr_idx_c  = wr_idx[3:0];
    assign rsv_idx_c = rsv_idx[3:0];

    always #5 clk = ~clk;

    regfile_mp #(.NREGS(32), .XLEN(32), .NRPORTS(2), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_a),
        .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx));

    regfile_mp #(.NREGS(32), .XLEN(32), .NRPORTS(2), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b),
        .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx));

    regfile_mp #(.NREGS(16), .XLEN(32), .NRPORTS(3), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_c),
        .rd_idx(rd_idx_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en), .wr_idx(wr_idx_c), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx_c));

    // Inputs change 1ns after the rising edge; outputs sampled there or at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_req = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
        wr_idx = '0; rsv_idx = '0; wr_data = '0;
    endtask

    // Ticks up to 40 edges, reporting the first tick index at which each ready is high (-1 = never).
    task automatic wait_ready(output int ta, output int tb, output int tc);
        ta = -1; tb = -1; tc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ta < 0 && ready_a === 1'b1) ta = i;
            if (tb < 0 && ready_b === 1'b1) tb = i;
            if (tc < 0 && ready_c === 1'b1) tc = i;
        end
    endtask

    task automatic test_reset();
        int ta, tb, tc, bad;
        rst = 1'b0; idle(); rd_idx = '0; rd_idx_c = '0;
        repeat (3) tick();
        n_cmp++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            n_err++; $display("FAIL reset_ready: got %b exp 000", {ready_a, ready_b, ready_c});
        end
        rst = 1'b1;
        wait_ready(ta, tb, tc);
        n_cmp++;
        if (ta != 31 || tb != 31) begin
            n_err++; $display("FAIL reset_ready_latency_32: got %0d/%0d exp 31", ta, tb);
        end
        n_cmp++;
        if (tc != 15) begin
            n_err++; $display("FAIL reset_ready_latency_16: got %0d exp 15", tc);
        end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            rd_idx[0] = 5'(r); rd_idx[1] = 5'(31 - r);
            rd_idx_c[0] = 4'(r); rd_idx_c[1] = 4'(r + 1); rd_idx_c[2] = 4'(r + 2);
            #1;
            if (rd_data_a !== '0 || rd_data_b !== '0 || rd_data_c !== '0 ||
                rd_busy_a !== '0 || rd_busy_c !== '0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL reset_all_zero: got %0d nonzero reads exp 0", bad);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF; rd_idx[0] = 5'd5; rd_idx[1] = 5'd6;
        @(negedge clk);
        n_cmp++;
        if (rd_data_a[0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_on: got %h exp deadbeef", rd_data_a[0]);
        end
        n_cmp++;
        if (rd_data_b[0] !== 32'h0) begin
            n_err++; $display("FAIL bypass_off: got %h exp 00000000", rd_data_b[0]);
        end
        n_cmp++;
        if (rd_data_a[1] !== 32'h0) begin
            n_err++; $display("FAIL bypass_other_port: got %h exp 00000000", rd_data_a[1]);
        end
        tick(); idle();
        n_cmp++;
        if (rd_data_a[0] !== 32'hDEADBEEF || rd_data_b[0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_next_cycle: got %h/%h exp deadbeef", rd_data_a[0], rd_data_b[0]);
        end
    endtask

    task automatic test_x0();
        wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_idx = 5'd0; rd_idx[0] = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (rd_data_a[0] !== 32'h0) begin
            n_err++; $display("FAIL x0_bypass: got %h exp 00000000", rd_data_a[0]);
        end
        tick(); idle();
        n_cmp++;
        if (rd_data_a[0] !== 32'h0 || rd_busy_a[0] !== 1'b0 || rd_data_b[0] !== 32'h0) begin
            n_err++; $display("FAIL x0_after: got data %h busy %b exp 0/0", rd_data_a[0], rd_busy_a[0]);
        end
    endtask

    task automatic test_busy();
        int ones;
        ones = 0; rd_idx[1] = 5'd7;
        // Reserve in cycle 0, write in cycle 4: busy visible in cycles 1..4.
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k == 0) begin rsv_en = 1'b1; rsv_idx = 5'd7; end
            if (k == 4) begin wr_en = 1'b1; wr_idx = 5'd7; wr_data = 32'h1; end
            @(negedge clk);
            if (rd_busy_a[1] === 1'b1) ones++;
            tick();
        end
        idle();
        n_cmp++;
        if (ones != 4) begin
            n_err++; $display("FAIL busy_window: got %0d cycles exp 4", ones);
        end
        n_cmp++;
        if (rd_data_a[1] !== 32'h1) begin
            n_err++; $display("FAIL busy_write_data: got %h exp 00000001", rd_data_a[1]);
        end
        wr_en = 1'b1; wr_idx = 5'd9; wr_data = 32'hCAFEF00D;
        rsv_en = 1'b1; rsv_idx = 5'd9; rd_idx[0] = 5'd9;
        @(negedge clk);
        n_cmp++;
        if (rd_busy_a[0] !== 1'b0) begin
            n_err++; $display("FAIL busy_no_bypass: got %b exp 0", rd_busy_a[0]);
        end
        tick(); idle();
        n_cmp++;
        if (rd_busy_a[0] !== 1'b1 || rd_data_a[0] !== 32'hCAFEF00D || rd_data_b[0] !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL rsv_wr_same: got busy %b data %h exp 1/cafef00d", rd_busy_a[0], rd_data_a[0]);
        end
    endtask

    task automatic test_clear();
        int ta, tb, tc;
        wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'hA5A5A5A5; rsv_en = 1'b1; rsv_idx = 5'd3;
        tick(); idle();
        rd_idx[0] = 5'd3;
        #1;
        n_cmp++;
        if (rd_data_a[0] !== 32'hA5A5A5A5 || rd_busy_a[0] !== 1'b1) begin
            n_err++; $display("FAIL clear_setup: got %h busy %b exp a5a5a5a5/1", rd_data_a[0], rd_busy_a[0]);
        end
        clr_req = 1'b1;
        tick(); idle();
        n_cmp++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            n_err++; $display("FAIL clear_ready_fall: got %b%b exp 00", ready_a, ready_b);
        end
        // Write, reserve and a repeated clear request during CLEAR are all ignored.
        wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'h11111111; rsv_en = 1'b1; rsv_idx = 5'd3; clr_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_data_a[0] !== 32'h0 || rd_busy_a[0] !== 1'b0) begin
            n_err++; $display("FAIL clear_reads_zero: got %h busy %b exp 0/0", rd_data_a[0], rd_busy_a[0]);
        end
        tick(); idle();
        // One CLEAR edge already taken, so 30 more make 31 total.
        wait_ready(ta, tb, tc);
        n_cmp++;
        if (ta != 30 || tb != 30) begin
            n_err++; $display("FAIL clear_latency: got %0d/%0d exp 30", ta, tb);
        end
        n_cmp++;
        if (rd_data_a[0] !== 32'h0 || rd_busy_a[0] !== 1'b0 || rd_data_b[0] !== 32'h0) begin
            n_err++; $display("FAIL clear_x3: got %h busy %b exp 0/0", rd_data_a[0], rd_busy_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        int ta, tb, tc;
        clr_req = 1'b1;
        tick(); idle();
        repeat (9) tick();   // counter now at 10 on both sizes
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_ready(ta, tb, tc);
        n_cmp++;
        if (ta != 31 || tc != 15) begin
            n_err++; $display("FAIL reset_mid_clear: got %0d/%0d exp 31/15", ta, tc);
        end
        // Async reset while READY: ready drops before any clock edge.
        rsv_en = 1'b1; rsv_idx = 5'd7;
        tick(); idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready_a !== 1'b0 || ready_c !== 1'b0) begin
            n_err++; $display("FAIL reset_async: got %b%b exp 00", ready_a, ready_c);
        end
        tick();
        rst = 1'b1;
        wait_ready(ta, tb, tc);
        n_cmp++;
        if (ta != 31 || tb != 31 || tc != 15) begin
            n_err++; $display("FAIL reset_mid_op: got %0d/%0d/%0d exp 31/31/15", ta, tb, tc);
        end
        rd_idx[0] = 5'd7; rd_idx[1] = 5'd9;
        #1;
        n_cmp++;
        if (rd_busy_a !== 2'b00 || rd_data_a[1] !== 32'h0) begin
            n_err++; $display("FAIL reset_mid_state: got busy %b data %h exp 00/0", rd_busy_a, rd_data_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_busy();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
